// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the word PC, drives the imem req/ready handshake, feeds IF/ID.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module if_fetch_stage #(
  parameter int unsigned         PC_W     = 30,
  parameter logic [PC_W-1:0]     RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hazard,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] pc_plus_4,
  output logic [31:0]     if_ins,
  output logic            if_valid,
  output logic            flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] KILL  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic [PC_W-1:0] ppc_q, ppc_d;
  logic [31:0]     ins_q, ins_d;
  logic            valid_q, valid_d;
  logic            flush_q, flush_d;
  logic            fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      ppc_q   <= '0;
      ins_q   <= '0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      ppc_q   <= ppc_d;
      ins_q   <= ins_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
    end
  end

  // A stalled HOLD re-issues on the cycle hazard drops; a raised request is never retracted.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    ppc_d     = ppc_q;
    ins_d     = ins_q;
    valid_d   = valid_q;
    flush_d   = 1'b0;
    imem_addr = pc_q;
    imem_req  = !rst && ((state_q != HOLD) || (!hazard && !redirect_valid));
    fire      = imem_req && imem_ready;

    case (state_q)
      KILL: begin
        valid_d = 1'b0;
        if (redirect_valid) begin
          tgt_d   = redirect_target;
          flush_d = 1'b1;
        end
        if (fire) begin
          pc_d    = redirect_valid ? redirect_target : tgt_q;
          state_d = FETCH;
        end
      end
      default: begin
        if (redirect_valid) begin
          flush_d = 1'b1;
          valid_d = 1'b0;
          if (imem_req && !imem_ready) begin
            tgt_d   = redirect_target;
            state_d = KILL;
          end else begin
            pc_d    = redirect_target;
            state_d = FETCH;
          end
        end else if (imem_req) begin
          if (imem_ready) begin
            ins_d   = imem_rdata;
            ppc_d   = PC_W'(pc_q + 1'b1);
            pc_d    = PC_W'(pc_q + 1'b1);
            valid_d = 1'b1;
            state_d = hazard ? HOLD : FETCH;
          end else begin
            valid_d = 1'b0;
            state_d = FETCH;
          end
        end
      end
    endcase
  end

  assign pc_plus_4 = ppc_q;
  assign if_ins    = ins_q;
  assign if_valid  = valid_q;
  assign flush     = flush_q;

`ifdef FETCH_PERF_CNT_EN
  logic accept;
  logic stall_evt;

  assign accept    = fire && !redirect_valid && (state_q != KILL);
  assign stall_evt = (imem_req && !imem_ready) || (state_q == HOLD);

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (accept && (perf_fetched != 32'hFFFF_FFFF)) perf_fetched <= perf_fetched + 32'd1;
      if (stall_evt && (perf_stall != 32'hFFFF_FFFF)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus random traffic against a behavioural model.
module tb_if_fetch_stage;
  localparam int unsigned     PC_W   = 30;
  localparam logic [PC_W-1:0] RST_PC = 30'h100;

  logic            clk = 1'b0;
  logic            rst, hazard, redirect_valid, imem_ready;
  logic [PC_W-1:0] redirect_target;
  logic [31:0]     imem_rdata;
  logic            imem_req, if_valid, flush;
  logic [PC_W-1:0] imem_addr, pc_plus_4;
  logic [31:0]     if_ins;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     perf_fetched, perf_stall;
`endif

  if_fetch_stage #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .hazard(hazard),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pc_plus_4(pc_plus_4), .if_ins(if_ins), .if_valid(if_valid), .flush(flush)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: pc being fetched, a pending killed request, stall hold, and the IF/ID-facing values.
  logic [PC_W-1:0] m_pc, m_tgt, m_ppc;
  logic [31:0]     m_ins;
  logic            m_hold, m_kill, m_valid, m_flush;
  logic            last_req;
  logic [PC_W-1:0] last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_tgt = RST_PC; m_ppc = '0; m_ins = '0;
    m_hold = 1'b0; m_kill = 1'b0; m_valid = 1'b0; m_flush = 1'b0;
  endtask

  // One clock: drive inputs, compare mid-cycle, advance the model across the edge.
  task automatic step(input logic r, input logic h, input logic rv, input logic [PC_W-1:0] rt,
                      input logic rdy, input logic [31:0] rd);
    logic exp_req, done;
    rst = r; hazard = h; redirect_valid = rv; redirect_target = rt;
    imem_ready = rdy; imem_rdata = rd;
    #3;
    exp_req = !r && (!m_hold || (!h && !rv));
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", if_valid, m_valid);
    chk("if_ins", if_ins, m_ins);
    chk("pc_plus_4", pc_plus_4, m_ppc);
    chk("flush", flush, m_flush);
    last_req = imem_req; last_addr = imem_addr;
    @(posedge clk); #1;
    done = exp_req && rdy;
    if (r) begin
      model_reset();
    end else begin
      m_flush = rv;
      if (m_kill) begin
        m_valid = 1'b0;
        if (rv) m_tgt = rt;
        if (done) begin m_pc = m_tgt; m_kill = 1'b0; end
      end else if (rv) begin
        m_valid = 1'b0; m_hold = 1'b0;
        if (exp_req && !rdy) begin m_kill = 1'b1; m_tgt = rt; end
        else m_pc = rt;
      end else if (done) begin
        m_ins = rd; m_pc = m_pc + 1'b1; m_ppc = m_pc; m_valid = 1'b1; m_hold = h;
      end else if (exp_req) begin
        m_valid = 1'b0; m_hold = 1'b0;
      end
    end
  endtask

  initial begin
    logic [PC_W-1:0] rt;
    rst = 1'b1; hazard = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    imem_ready = 1'b0; imem_rdata = '0;
    @(posedge clk); #1;
    model_reset();

    // Reset and back-to-back fetch from RESET_PC.
    step(1, 0, 0, '0, 1, 32'h1111_1111);
    chk("L_rst_req", last_req, 0);
    chk("L_rst_valid", if_valid, 0);
    chk("L_rst_ppc", pc_plus_4, 0);
    chk("L_rst_ins", if_ins, 0);
    chk("L_rst_flush", flush, 0);
    step(0, 0, 0, '0, 1, 32'hA000_0100);
    chk("L_addr100", last_addr, 30'h100);
    chk("L_ppc101", pc_plus_4, 30'h101);
    chk("L_ins100", if_ins, 32'hA000_0100);
    step(0, 0, 0, '0, 1, 32'hA000_0101);
    chk("L_addr101", last_addr, 30'h101);
    chk("L_ppc102", pc_plus_4, 30'h102);
    step(0, 0, 0, '0, 1, 32'hA000_0102);
    chk("L_addr102", last_addr, 30'h102);
    chk("L_ppc103", pc_plus_4, 30'h103);
    chk("L_flush0", flush, 0);
    step(0, 0, 0, '0, 1, 32'hA000_0103);

    // Three wait cycles at 104.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, '0, 0, 32'hDEAD_0000);
      chk("L_wait_addr104", last_addr, 30'h104);
      chk("L_wait_valid0", if_valid, 0);
    end
    step(0, 0, 0, '0, 1, 32'hB000_0104);
    chk("L_ins104", if_ins, 32'hB000_0104);
    chk("L_ppc105", pc_plus_4, 30'h105);

    // Redirect to 200, then a two-cycle hazard hold.
    step(0, 0, 1, 30'h200, 1, 32'hDEAD_0105);
    chk("L_redir_flush", flush, 1);
    chk("L_redir_valid0", if_valid, 0);
    step(0, 1, 0, '0, 1, 32'hC000_0200);
    chk("L_addr200", last_addr, 30'h200);
    chk("L_ppc201", pc_plus_4, 30'h201);
    chk("L_flush_once", flush, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, '0, 1, 32'hDEAD_0201);
      chk("L_hold_req0", last_req, 0);
      chk("L_hold_ppc201", pc_plus_4, 30'h201);
      chk("L_hold_ins", if_ins, 32'hC000_0200);
    end
    step(0, 0, 0, '0, 1, 32'hC000_0201);
    chk("L_unhold_req", last_req, 1);
    chk("L_unhold_addr201", last_addr, 30'h201);

    // Redirect while a request at 210 is waiting.
    step(0, 0, 1, 30'h210, 1, 32'hDEAD_0202);
    step(0, 0, 0, '0, 0, 32'hDEAD_0210);
    step(0, 0, 1, 30'h400, 0, 32'hDEAD_0210);
    chk("L_kill_flush", flush, 1);
    step(0, 0, 0, '0, 0, 32'hDEAD_0210);
    chk("L_kill_stale_addr", last_addr, 30'h210);
    chk("L_kill_flush_once", flush, 0);
    step(0, 0, 0, '0, 1, 32'hDEAD_0210);
    chk("L_kill_drop", if_valid, 0);
    step(0, 0, 0, '0, 1, 32'hD000_0400);
    chk("L_addr400", last_addr, 30'h400);
    chk("L_ppc401", pc_plus_4, 30'h401);

    // PC wrap, then reset in the middle of a wait.
    step(0, 0, 1, 30'h3FFF_FFFF, 1, 32'hDEAD_0401);
    step(0, 0, 0, '0, 1, 32'hE000_FFFF);
    chk("L_addr_top", last_addr, 30'h3FFF_FFFF);
    chk("L_wrap_ppc0", pc_plus_4, 30'h0);
    step(0, 0, 0, '0, 0, 32'hDEAD_0000);
    chk("L_wrap_addr0", last_addr, 30'h0);
    step(1, 0, 0, '0, 1, 32'hDEAD_0000);
    chk("L_midrst_valid", if_valid, 0);
    chk("L_midrst_ppc", pc_plus_4, 0);
    step(0, 0, 0, '0, 0, 32'hDEAD_0000);
    chk("L_midrst_addr", last_addr, RST_PC);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rt = PC_W'($urandom);
      if ($urandom_range(0, 3) == 0) rt = 30'h3FFF_FFFC + PC_W'($urandom_range(0, 3));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           rt, $urandom_range(0, 1) == 1, $urandom);
    end

`ifdef FETCH_PERF_CNT_EN
    // 10 accepted fetches and 4 wait cycles.
    step(1, 0, 0, '0, 0, '0);
    begin
      logic [13:0] pat;
      pat = 14'b11_0111_0110_0111;
      for (int i = 0; i < 14; i++) step(0, 0, 0, '0, pat[i], $urandom);
    end
    chk("L_perf_fetched", perf_fetched, 32'd10);
    chk("L_perf_stall", perf_stall, 32'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the word-addressed PC and issues requests to instruction memory over a req/ready handshake.
- Delivers pc_plus_4 and if_ins to IF/ID; raises flush toward IF/ID on branch/jump redirect.
- Honours load-use stalls (hazard) and discards in-flight fetches killed by a redirect.

Parameters:
- RESET_PC, 30'h0000_0000, word address of the first fetch after reset.
- PC_W, 30, PC width in words; byte address is {pc, 2'b00}.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- hazard  input  1  stall from hazard unit; hold PC and the current output.
- redirect_valid  input  1  branch taken or jump resolved in ID/EX.
- redirect_target  input  PC_W  new word address.
- imem_req  output  1  fetch request valid.
- imem_addr  output  PC_W  word address being fetched.
- imem_ready  input  1  memory returns data this cycle; completes the request.
- imem_rdata  input  32  instruction word; valid when imem_ready=1.
- pc_plus_4  output  PC_W  word address of the fetched instruction + 1, to IF/ID.
- if_ins  output  32  fetched instruction, to IF/ID.
- if_valid  output  1  pc_plus_4/if_ins hold a live instruction.
- flush  output  1  one-cycle pulse: IF/ID must load a bubble (0).

Behaviour:
- Reset (rst=1 at clk edge):
  - pc=RESET_PC, state=FETCH.
  - imem_req=0, if_valid=0, if_ins=0, pc_plus_4=0, flush=0.
  - A reset mid-request abandons that request, and any imem_ready that follows is ignored.
- State FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready with no redirect: if_ins<=imem_rdata, pc_plus_4<=pc+1, if_valid<=1, pc<=pc+1.
  - Next state is FETCH if hazard=0, else HOLD.
  - With no imem_ready: if_valid<=0 and the address is held stable.
- State HOLD (stalled with a captured instruction):
  - imem_req=0; pc, if_ins, pc_plus_4 and if_valid are held.
  - Return to FETCH on the first cycle with hazard=0; the new request issues that cycle.
- hazard in FETCH with no outstanding data: keep imem_req high. Once req is raised, imem_addr must not change until ready.
- Redirect (redirect_valid=1), priority over hazard:
  - pc<=redirect_target, flush<=1 for exactly one cycle, if_valid<=0.
  - In FETCH with imem_ready the same cycle: returned data is discarded and the next request is to redirect_target.
  - In FETCH without imem_ready: go to KILL.
- State KILL:
  - imem_req stays 1 with the stale address until imem_ready, because the handshake cannot be retracted.
  - That data is dropped, then state goes to FETCH with pc=target.
  - A further redirect in KILL overwrites the target, flush pulses again, and state stays KILL.
- Arithmetic: pc+1 wraps modulo 2^PC_W (30'h3FFF_FFFF+1 = 0), with no error.
- Latency: with ready at the first req cycle, one instruction per cycle. Data appears on if_ins the cycle after imem_ready.
- flush is registered and is never asserted in the reset cycle.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_fetched (32) and perf_stall (32), both reset to 0 and saturating at 32'hFFFF_FFFF.
  - perf_fetched increments on every accepted (non-discarded) instruction.
  - perf_stall increments on every cycle with imem_req=1 && imem_ready=0, or state=HOLD.
- When undefined: the ports and logic are absent and the remaining behaviour is identical.

Test Plan:
- Reset, RESET_PC=30'h100, imem_ready=1 always -> imem_addr 100,101,102 on consecutive cycles; pc_plus_4 101,102,103 one cycle later; flush=0.
- imem_ready low 3 cycles at addr 30'h104 -> imem_addr held at 104, if_valid=0 for those cycles; on ready, if_ins=rdata and pc_plus_4=105.
- hazard high 2 cycles after fetching 30'h200 -> if_ins/pc_plus_4 (201) held, imem_req=0; the next request is to 201 on the cycle hazard drops.
- redirect_valid to 30'h400 while a request at 30'h210 is waiting 2 cycles:
  - flush pulses exactly 1 cycle and the 210 data is dropped (if_valid stays 0).
  - The next request is to 400, followed by pc_plus_4=401.
- pc=30'h3FFF_FFFF fetched -> pc_plus_4=0 and the next imem_addr=0; separately, rst asserted mid-wait -> outputs at reset values and the first request is to RESET_PC.
- With FETCH_PERF_CNT_EN: 10 fetches and 4 wait cycles -> perf_fetched=10, perf_stall=4.
